// File: rtl/riscv_pkg.sv
// Shared constants for the instruction-fetch front end.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush. DEPTH is a power of two, so the pointers wrap on their own.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues word requests, tracks in-flight responses,
// queues {pc, instr} for decode and squashes stale work on a redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int              CW  = $clog2(QDEPTH + 1);
  localparam int              FW  = 2 * XLEN;
  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redirect_aligned;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, q_count;
  logic [CW:0]     inflight;
  logic            accept, resp, drop, push, pop, fifo_empty;
  logic [FW-1:0]   fifo_head;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    redirect_aligned = redirect_pc & ~XLEN'(3);
    inflight = {1'b0, q_count} + {1'b0, out_q};
    // Queued plus outstanding is capped, so each response always finds a free slot.
    imem_req = !rst && !redirect_valid && (inflight < (CW + 1)'(QDEPTH));
    accept   = imem_req && imem_gnt;
    resp     = imem_rvalid && (out_q != '0);
    drop     = resp && (drop_q != '0);
    push     = resp && !drop && !redirect_valid;
    pop      = if_valid && if_ready && !redirect_valid;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q;
    case ({accept, resp})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
    if (accept) fetch_pc_d = fetch_pc_q + INC;
    if (push)   resp_pc_d  = resp_pc_q + INC;
    if (drop)   drop_d     = drop_q - CW'(1);
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_d     = out_q - CW'(resp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .W     (FW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({resp_pc_q, imem_rdata}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (q_count)
  );

  assign imem_addr = fetch_pc_q & ~XLEN'(3);
  assign if_valid  = !fifo_empty;
  assign if_pc     = if_valid ? fifo_head[FW-1:XLEN] : '0;
  assign if_instr  = if_valid ? fifo_head[XLEN-1:0]  : '0;

  a_no_spurious_rvalid: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid |-> (out_q != '0)
  );

endmodule
